// File: rtl/digit_serial_comparator_pkg.sv
// Shared types and predicate decode for the digit-serial comparator.
// Predicate codes 6 and 7 are reserved and always evaluate to 0.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ = 3'd0,
    OP_NE = 3'd1,
    OP_LT = 3'd2,
    OP_LE = 3'd3,
    OP_GT = 3'd4,
    OP_GE = 3'd5
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  function automatic logic pred_eval(input logic [2:0] op, input logic lt, input logic gt);
    logic eq;
    eq = ~lt & ~gt;
    case (op)
      OP_EQ:   pred_eval = eq;
      OP_NE:   pred_eval = ~eq;
      OP_LT:   pred_eval = lt;
      OP_LE:   pred_eval = lt | eq;
      OP_GT:   pred_eval = gt;
      OP_GE:   pred_eval = gt | eq;
      default: pred_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/digit_serial_comparator_digit.sv
// Combinational single-digit magnitude compare; flip_msb inverts the top bit
// of both digits so two's-complement sign ordering becomes unsigned ordering.
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             flip_msb,
  output logic             lt_d,
  output logic             gt_d
);

  logic [DIGIT-1:0] w_a;
  logic [DIGIT-1:0] w_b;

  // Conditionally flip the sign bit, then compare magnitudes.
  always_comb begin
    w_a            = a_d;
    w_b            = b_d;
    w_a[DIGIT-1]   = a_d[DIGIT-1] ^ flip_msb;
    w_b[DIGIT-1]   = b_d[DIGIT-1] ^ flip_msb;
    lt_d           = (w_a < w_b);
    gt_d           = (w_a > w_b);
  end

endmodule

// File: rtl/digit_serial_comparator.sv
// Digit-serial signed/unsigned comparator, MSD first, valid/ready on both sides.
// Build macro DIGIT_SERIAL_COMPARATOR_EARLY_EXIT_EN ends the scan at the first differing digit.
module digit_serial_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             signed_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             out_lt,
  output logic             out_eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = $clog2(NDIG + 1);

  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("digit_serial_comparator: illegal WIDTH/DIGIT combination");
  end

  cmp_state_e        r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_op;
  logic              r_signed;
  logic              r_lt;
  logic              r_gt;
  logic [IDXW-1:0]   r_idx;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_result;
  logic              r_out_lt;
  logic              r_out_eq;

  logic              w_flip;
  logic              w_lt_d;
  logic              w_gt_d;
  logic              w_lt_n;
  logic              w_gt_n;
  logic              w_last;
  logic              w_stop;

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d      (r_a[WIDTH-1 -: DIGIT]),
    .b_d      (r_b[WIDTH-1 -: DIGIT]),
    .flip_msb (w_flip),
    .lt_d     (w_lt_d),
    .gt_d     (w_gt_d)
  );

  // Next-flag logic: once a decision is taken the flags stay frozen.
  always_comb begin
    w_flip = r_signed & (r_idx == IDXW'(NDIG - 1));
    w_lt_n = r_lt | (~r_gt & w_lt_d);
    w_gt_n = r_gt | (~r_lt & w_gt_d);
    w_last = (r_idx == {IDXW{1'b0}});
`ifdef DIGIT_SERIAL_COMPARATOR_EARLY_EXIT_EN
    w_stop = w_last | w_lt_n | w_gt_n;
`else
    w_stop = w_last;
`endif
  end

  // Control FSM, operand shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_op        <= 3'd0;
      r_signed    <= 1'b0;
      r_lt        <= 1'b0;
      r_gt        <= 1'b0;
      r_idx       <= {IDXW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 1'b0;
      r_out_lt    <= 1'b0;
      r_out_eq    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_signed   <= signed_en;
            r_lt       <= 1'b0;
            r_gt       <= 1'b0;
            r_idx      <= IDXW'(NDIG - 1);
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_lt <= w_lt_n;
          r_gt <= w_gt_n;
          r_a  <= r_a << DIGIT;
          r_b  <= r_b << DIGIT;
          if (w_stop) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= pred_eval(r_op, w_lt_n, w_gt_n);
            r_out_lt    <= w_lt_n;
            r_out_eq    <= ~w_lt_n & ~w_gt_n;
          end else begin
            r_idx <= r_idx - {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign out_lt    = r_out_lt;
  assign out_eq    = r_out_eq;

endmodule
